// File: rtl/x_seq_div.sv
// x_seq_div: multi-cycle restoring integer divider.
//
// Produces one quotient bit per clock using a WIDTH+1-bit subtract-and-restore
// step. There is a valid/ready request interface and a valid/ready response
// interface. Only one operation is in flight at a time. Divide-by-zero and
// signed overflow results follow RISC-V M-extension semantics.
//
// Optional feature macro: X_DIV_SIGNED_EN
//   When defined, op_signed=1 selects signed division on absolute values,
//   followed by sign correction in the FIX state.
//   When undefined, op_signed is ignored and every operation is unsigned.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst          synchronous, active-high reset
//   in_valid     request present
//   in_ready     divider can accept a request (high only in IDLE)
//   dividend     numerator, WIDTH bits
//   divisor      denominator, WIDTH bits
//   op_signed    1 = signed operation (only honoured with X_DIV_SIGNED_EN)
//   out_valid    result present (high only in DONE)
//   out_ready    consumer accepts the result
//   quotient     result quotient, WIDTH bits
//   remainder    result remainder, WIDTH bits
//   div_by_zero  result came from a zero divisor

module x_seq_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             op_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  // Q shifts the dividend out from the top while quotient bits enter at the bottom.
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] r_reg, r_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic [WIDTH-1:0] quotient_reg, quotient_next;
  logic [WIDTH-1:0] remainder_reg, remainder_next;
  logic             dbz_reg, dbz_next;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;

  // One restoring step: shift the next dividend bit into R, then try subtracting D.
  // R < D always holds, so R' < 2D fits in WIDTH+1 bits, and bit WIDTH of the
  // difference is a clean borrow flag.
  logic [WIDTH:0] r_shift;
  logic [WIDTH:0] diff;

  assign r_shift = {r_reg, q_reg[WIDTH-1]};
  assign diff    = r_shift - {1'b0, d_reg};

`ifdef X_DIV_SIGNED_EN
  logic dvd_neg, dvs_neg;
  logic neg_q_reg, neg_q_next;
  logic neg_r_reg, neg_r_next;

  assign dvd_neg = op_signed & dividend[WIDTH-1];
  assign dvs_neg = op_signed & divisor[WIDTH-1];
  // The most-negative value maps to itself, which is also its correct
  // unsigned magnitude, so overflow needs no special path.
  assign dvd_mag = dvd_neg ? ({WIDTH{1'b0}} - dividend) : dividend;
  assign dvs_mag = dvs_neg ? ({WIDTH{1'b0}} - divisor) : divisor;
`else
  logic unused_op_signed;
  assign unused_op_signed = op_signed;
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      q_reg         <= '0;
      r_reg         <= '0;
      d_reg         <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
`ifdef X_DIV_SIGNED_EN
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      q_reg         <= q_next;
      r_reg         <= r_next;
      d_reg         <= d_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      dbz_reg       <= dbz_next;
`ifdef X_DIV_SIGNED_EN
      neg_q_reg     <= neg_q_next;
      neg_r_reg     <= neg_r_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    q_next         = q_reg;
    r_next         = r_reg;
    d_next         = d_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    dbz_next       = dbz_reg;
`ifdef X_DIV_SIGNED_EN
    neg_q_next     = neg_q_reg;
    neg_r_next     = neg_r_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (divisor == '0) begin
            // Result is known at once; the remainder is the original, unconverted dividend.
            quotient_next  = '1;
            remainder_next = dividend;
            dbz_next       = 1'b1;
            state_next     = DONE;
          end else begin
            q_next     = dvd_mag;
            d_next     = dvs_mag;
            r_next     = '0;
            dbz_next   = 1'b0;
            count_next = CNT_W'(WIDTH);
`ifdef X_DIV_SIGNED_EN
            neg_q_next = dvd_neg ^ dvs_neg;
            neg_r_next = dvd_neg;
`endif
            state_next = CALC;
          end
        end
      end

      CALC: begin
        if (!diff[WIDTH]) begin
          r_next = diff[WIDTH-1:0];
          q_next = {q_reg[WIDTH-2:0], 1'b1};
        end else begin
          r_next = r_shift[WIDTH-1:0];
          q_next = {q_reg[WIDTH-2:0], 1'b0};
        end
        count_next = count_reg - CNT_W'(1);
        if (count_reg == CNT_W'(1)) begin
          state_next = FIX;
        end
      end

      FIX: begin
`ifdef X_DIV_SIGNED_EN
        quotient_next  = neg_q_reg ? ({WIDTH{1'b0}} - q_reg) : q_reg;
        remainder_next = neg_r_reg ? ({WIDTH{1'b0}} - r_reg) : r_reg;
`else
        quotient_next  = q_reg;
        remainder_next = r_reg;
`endif
        dbz_next   = 1'b0;
        state_next = DONE;
      end

      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign in_ready    = (state_reg == IDLE);
  assign out_valid   = (state_reg == DONE);
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_x_seq_div.sv
// Directed testbench for x_seq_div (WIDTH=32). Signed cases are compiled in
// only when X_DIV_SIGNED_EN is defined. Otherwise, the same inputs are checked
// to produce unsigned results.

module tb_x_seq_div;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         op_signed;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  x_seq_div #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .dividend(dividend),
    .divisor(divisor),
    .op_signed(op_signed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach summary in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count edges from the accept edge until out_valid; a bound of 200 keeps a dead DUT from hanging.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  // Full transaction with an always-ready consumer, plus the post-handshake state.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sgn, input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edbz, input int elat);
    int lat;
    check({tag, " in_ready before"}, W'(in_ready), W'(1));
    dividend  = a;
    divisor   = b;
    op_signed = sgn;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_result(lat);
    check({tag, " latency"}, W'(lat), W'(elat));
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, W'(div_by_zero), W'(edbz));
    $display("op %s: %0h / %0h -> q=%0h r=%0h dbz=%0d lat=%0d", tag, a, b, quotient, remainder, div_by_zero, lat);
    tick();
    check({tag, " out_valid after hs"}, W'(out_valid), W'(0));
    check({tag, " in_ready after hs"}, W'(in_ready), W'(1));
  endtask

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    op_signed = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("reset in_ready", W'(in_ready), W'(1));
    check("reset out_valid", W'(out_valid), W'(0));
    check("reset quotient", quotient, W'(0));
    check("reset remainder", remainder, W'(0));
    check("reset div_by_zero", W'(div_by_zero), W'(0));
    rst = 1'b0;
    tick();

    // Basic unsigned cases and boundaries.
    run_op("100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34);
    run_op("5/0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
    run_op("7/100", 32'd7, 32'd100, 1'b0, 32'd0, 32'd7, 1'b0, 34);
    run_op("12345678/1000", 32'd12345678, 32'd1000, 1'b0, 32'd12345, 32'd678, 1'b0, 34);
    run_op("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'd0, 1'b0, 34);

    // Back-to-back: the second request stays asserted but waits for the first handshake.
    dividend  = 32'hFFFF_FFFF;
    divisor   = 32'd1;
    op_signed = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    dividend = 32'd3;
    divisor  = 32'hFFFF_FFFF;
    check("b2b busy in_ready", W'(in_ready), W'(0));
    wait_result(lat);
    check("b2b first latency", W'(lat), W'(34));
    check("b2b first quotient", quotient, 32'hFFFF_FFFF);
    check("b2b first remainder", remainder, 32'd0);
    $display("op b2b first: q=%0h r=%0h lat=%0d", quotient, remainder, lat);
    tick();
    check("b2b in_ready after hs", W'(in_ready), W'(1));
    check("b2b out_valid after hs", W'(out_valid), W'(0));
    tick();
    in_valid = 1'b0;
    check("b2b second accepted", W'(in_ready), W'(0));
    wait_result(lat);
    check("b2b second latency", W'(lat), W'(34));
    check("b2b second quotient", quotient, 32'd0);
    check("b2b second remainder", remainder, 32'd3);
    $display("op b2b second: q=%0h r=%0h lat=%0d", quotient, remainder, lat);
    tick();

    // Backpressure: the result is held and new requests are ignored.
    dividend  = 32'd100;
    divisor   = 32'd7;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_result(lat);
    check("bp latency", W'(lat), W'(34));
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      dividend = 32'd50 + 32'(i);
      divisor  = 32'd3;
      tick();
      check("bp out_valid", W'(out_valid), W'(1));
      check("bp quotient", quotient, 32'd14);
      check("bp remainder", remainder, 32'd2);
      check("bp in_ready", W'(in_ready), W'(0));
    end
    $display("op backpressure: held q=%0h r=%0h for 10 cycles", quotient, remainder);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp in_ready after hs", W'(in_ready), W'(1));
    check("bp out_valid after hs", W'(out_valid), W'(0));

    // Reset in the middle of a calculation.
    dividend = 32'd1000;
    divisor  = 32'd10;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("abort still busy", W'(out_valid), W'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort out_valid", W'(out_valid), W'(0));
    check("abort in_ready", W'(in_ready), W'(1));
    check("abort quotient", quotient, W'(0));
    $display("op abort: reset during 1000/10");
    run_op("9/4 after abort", 32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 1'b0, 34);

    // Signed-looking operands with op_signed=0 are always unsigned.
    run_op("-7/2 unsigned", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 34);

`ifdef X_DIV_SIGNED_EN
    run_op("-7/2 signed", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34);
    run_op("7/-2 signed", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 34);
    run_op("-7/-2 signed", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3, 32'hFFFF_FFFF, 1'b0, 34);
    run_op("overflow signed", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 34);
    run_op("-7/0 signed", 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1);
`else
    // Without the signed feature, op_signed=1 must not change the result.
    run_op("-7/2 op_signed ignored", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, 34);
    run_op("min/-1 op_signed ignored", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 34);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
